// File: rtl/mig_app_responder_if.sv
// MIG 7-series app_* user-interface bundle between a memory client and the responder.
interface mig_app_responder_if #(
    parameter int unsigned DDR_DATA_WIDTH = 128,
    parameter int unsigned DDR_ADDR_WIDTH = 28
);
    logic                          app_en;
    logic [2:0]                    app_cmd;
    logic [DDR_ADDR_WIDTH-1:0]     app_addr;
    logic [DDR_DATA_WIDTH-1:0]     app_wdf_data;
    logic                          app_wdf_wren;
    logic                          app_wdf_end;
    logic [DDR_DATA_WIDTH/8-1:0]   app_wdf_mask;
    logic                          app_rdy;
    logic                          app_wdf_rdy;
    logic [DDR_DATA_WIDTH-1:0]     app_rd_data;
    logic                          app_rd_data_valid;
    logic                          app_rd_data_end;
    logic                          init_calib_complete;
    logic                          err_cmd;

    modport master (
        output app_en, app_cmd, app_addr, app_wdf_data, app_wdf_wren, app_wdf_end, app_wdf_mask,
        input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end,
               init_calib_complete, err_cmd
    );

    modport slave (
        input  app_en, app_cmd, app_addr, app_wdf_data, app_wdf_wren, app_wdf_end, app_wdf_mask,
        output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end,
               init_calib_complete, err_cmd
    );
endinterface

// File: rtl/mig_app_responder.sv
// On-chip-memory stand-in for the MIG 7-series user interface: queued masked writes,
// fixed-latency in-order reads, calibration delay and optional forced command stalls.
module mig_app_responder #(
    parameter int unsigned DDR_DATA_WIDTH = 128,
    parameter int unsigned DDR_ADDR_WIDTH = 28,
    parameter int unsigned MEM_AW         = 8,
    parameter int unsigned RD_LATENCY     = 4,
    parameter int unsigned CALIB_CYCLES   = 16,
    parameter int unsigned STALL_PERIOD   = 0
) (
    input  logic               clk,
    input  logic               rst,
    mig_app_responder_if.slave app
);
    localparam int unsigned MW    = DDR_DATA_WIDTH / 8;
    localparam int unsigned DEPTH = 2 ** MEM_AW;
    localparam int unsigned FD    = 4;
    localparam int unsigned PD    = RD_LATENCY - 1;
    localparam int unsigned CW    = $clog2(CALIB_CYCLES + 2);
    localparam int unsigned SW    = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
    localparam logic [2:0]  CMD_WR = 3'b000;
    localparam logic [2:0]  CMD_RD = 3'b001;

    logic [CW-1:0]             calib_cnt;
    logic                      calibrated;
    logic [SW-1:0]             stall_cnt;
    logic                      stall;
    logic                      rdy_q;
    logic                      wdf_rdy_q;
    logic                      err_q;

    logic [MEM_AW-1:0]         afifo      [FD];
    logic [DDR_DATA_WIDTH-1:0] dfifo_data [FD];
    logic [MW-1:0]             dfifo_mask [FD];
    logic [1:0]                a_wr, a_rd, d_wr, d_rd;
    logic [2:0]                a_cnt, d_cnt;

    logic                      rd_req;
    logic [MEM_AW-1:0]         rd_idx;
    logic [PD-1:0]             pipe_vld;
    logic [DDR_DATA_WIDTH-1:0] pipe_dat [PD];
    logic [DDR_DATA_WIDTH-1:0] mem      [DEPTH];

    logic                      acc_cmd, push_a, push_d, pop, is_rd, is_bad;
    logic [MEM_AW-1:0]         cmd_idx;
    logic [2:0]                a_cnt_n, d_cnt_n;
    logic                      calib_n, stall_n, rdy_n, wdf_rdy_n;
    logic [SW-1:0]             stall_cnt_n;
    logic                      unused_bits;

    assign unused_bits = ^{app.app_addr[DDR_ADDR_WIDTH-1:MEM_AW+3], app.app_addr[2:0], app.app_wdf_end};

    // Handshakes plus next-cycle ready flags, so the ready outputs come straight off flops
    always_comb begin
        cmd_idx     = app.app_addr[MEM_AW+2:3];
        acc_cmd     = app.app_en && rdy_q;
        push_a      = acc_cmd && (app.app_cmd == CMD_WR);
        is_rd       = acc_cmd && (app.app_cmd == CMD_RD);
        is_bad      = acc_cmd && (app.app_cmd != CMD_WR) && (app.app_cmd != CMD_RD);
        push_d      = app.app_wdf_wren && wdf_rdy_q;
        pop         = (a_cnt != 3'd0) && (d_cnt != 3'd0);
        a_cnt_n     = a_cnt + 3'(push_a) - 3'(pop);
        d_cnt_n     = d_cnt + 3'(push_d) - 3'(pop);
        calib_n     = calibrated || (calib_cnt == CW'(CALIB_CYCLES - 1));
        stall_cnt_n = (stall_cnt == SW'(STALL_PERIOD - 1)) ? '0 : stall_cnt + SW'(1);
        stall_n     = (STALL_PERIOD != 0) && (stall_cnt_n == SW'(STALL_PERIOD - 1));
        // A write waiting on its data blocks all commands, keeping reads behind writes
        rdy_n       = calib_n && (a_cnt_n != 3'd4) && !((a_cnt_n != 3'd0) && (d_cnt_n == 3'd0)) && !stall_n;
        wdf_rdy_n   = calib_n && (d_cnt_n != 3'd4);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            calib_cnt  <= '0;
            calibrated <= 1'b0;
            stall_cnt  <= '0;
            stall      <= 1'b0;
            rdy_q      <= 1'b0;
            wdf_rdy_q  <= 1'b0;
            err_q      <= 1'b0;
            a_wr       <= '0;
            a_rd       <= '0;
            d_wr       <= '0;
            d_rd       <= '0;
            a_cnt      <= '0;
            d_cnt      <= '0;
            rd_req     <= 1'b0;
            rd_idx     <= '0;
            pipe_vld   <= '0;
            for (int i = 0; i < PD; i++) pipe_dat[i] <= '0;
        end else begin
            if (!calibrated) calib_cnt <= calib_cnt + CW'(1);
            calibrated <= calib_n;
            stall_cnt  <= stall_cnt_n;
            stall      <= stall_n;
            rdy_q      <= rdy_n;
            wdf_rdy_q  <= wdf_rdy_n;
            if (is_bad) err_q <= 1'b1;
            if (push_a) a_wr <= a_wr + 2'd1;
            if (push_d) d_wr <= d_wr + 2'd1;
            if (pop) begin
                a_rd <= a_rd + 2'd1;
                d_rd <= d_rd + 2'd1;
            end
            a_cnt       <= a_cnt_n;
            d_cnt       <= d_cnt_n;
            rd_req      <= is_rd;
            rd_idx      <= cmd_idx;
            pipe_vld[0] <= rd_req;
            pipe_dat[0] <= mem[rd_idx];
            for (int i = 1; i < PD; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_dat[i] <= pipe_dat[i-1];
            end
        end
    end

    // FIFO storage and backing memory hold no reset state
    always_ff @(posedge clk) begin
        if (push_a) afifo[a_wr] <= cmd_idx;
        if (push_d) begin
            dfifo_data[d_wr] <= app.app_wdf_data;
            dfifo_mask[d_wr] <= app.app_wdf_mask;
        end
        if (pop) begin
            for (int b = 0; b < MW; b++) begin
                if (!dfifo_mask[d_rd][b]) mem[afifo[a_rd]][b*8 +: 8] <= dfifo_data[d_rd][b*8 +: 8];
            end
        end
    end

    assign app.app_rdy             = rdy_q;
    assign app.app_wdf_rdy         = wdf_rdy_q;
    assign app.init_calib_complete = calibrated;
    assign app.err_cmd             = err_q;
    assign app.app_rd_data         = pipe_dat[PD-1];
    assign app.app_rd_data_valid   = pipe_vld[PD-1];
    assign app.app_rd_data_end     = pipe_vld[PD-1];

    logic unused_stall;
    assign unused_stall = stall;
endmodule

// File: doc/mig_app_responder.md
Name: mig_app_responder

Overview:
- Synthesizable responder for the MIG 7-series user (app_*) interface, backed by on-chip memory.
- Stands in for the MIG core so the DDR burst controller and cache interface can be exercised in simulation and on-chip loopback without DDR3 pins.
- Accepts write and read commands with MIG handshake semantics: app_rdy and app_wdf_rdy backpressure, mask convention, in-order fixed-latency read return.

Parameters:
- DDR_DATA_WIDTH, 128, width of app_wdf_data and app_rd_data.
- DDR_ADDR_WIDTH, 28, width of app_addr.
- MEM_AW, 8, log2 of backing-store depth in DDR_DATA_WIDTH words.
- RD_LATENCY, 4, cycles from read acceptance to app_rd_data_valid; legal range 2..16.
- CALIB_CYCLES, 16, cycles after reset release before init_calib_complete rises.
- STALL_PERIOD, 0, forced app_rdy drop of one cycle every STALL_PERIOD cycles; 0 disables.

Ports:
- clk  in  1  user-interface clock (ui_clk domain).
- rst  in  1  asynchronous active-high reset.
- app_en  in  1  command valid.
- app_cmd  in  3  3'b000 write, 3'b001 read, others illegal.
- app_addr  in  DDR_ADDR_WIDTH  byte-lane address, BL8 x16 granularity.
- app_wdf_data  in  DDR_DATA_WIDTH  write data.
- app_wdf_wren  in  1  write data valid.
- app_wdf_end  in  1  last beat of write data; always paired with wren.
- app_wdf_mask  in  DDR_DATA_WIDTH/8  per-byte mask; 1 = byte NOT written.
- app_rdy  out  1  command accepted when app_en && app_rdy.
- app_wdf_rdy  out  1  data accepted when app_wdf_wren && app_wdf_rdy.
- app_rd_data  out  DDR_DATA_WIDTH  read data.
- app_rd_data_valid  out  1  read data valid.
- app_rd_data_end  out  1  equals app_rd_data_valid (single-beat 4:1 mode).
- init_calib_complete  out  1  ready indication.
- err_cmd  out  1  sticky; set on acceptance of an illegal app_cmd.

Behaviour:
- Reset values: all outputs 0, app_rd_data 0, FIFOs empty, read pipeline cleared, calibration counter 0. Backing memory is not cleared.
- Calibration: counter runs from reset release. init_calib_complete rises on cycle CALIB_CYCLES and stays high. app_rdy = app_wdf_rdy = 0 until then.
- Word index = app_addr[MEM_AW+2:3]. Bits [2:0] and bits above MEM_AW+2 are ignored, so higher addresses alias.
- Write path: two 4-entry FIFOs.
  - Write-address FIFO pushes on an accepted write command.
  - Write-data FIFO pushes {data, mask} on an accepted wdf beat.
  - Data may precede its command by up to 4 beats.
  - In any cycle where both FIFOs are non-empty, pop both; the masked write commits at that clock edge. One commit per cycle.
- app_wdf_rdy = calibrated && data FIFO not full.
- app_rdy = calibrated && !(addr FIFO full) && !(addr FIFO non-empty && data FIFO empty) && !stall slot. This blocks any command while a write awaits data, which guarantees read-after-write ordering.
- Read path:
  - A read accepted in cycle T registers its word index at the end of T.
  - The memory is read in T+1 and therefore sees every write committed at or before the T edge.
  - The result travels a shift pipeline so app_rd_data_valid pulses in cycle T+RD_LATENCY.
  - Back-to-back reads return back-to-back, in order. There is no read backpressure.
- Illegal cmd: accepted (app_rdy handshake completes), no memory access, err_cmd set until reset.
- Simultaneous wdf beat and write command in the same cycle: both pushes happen. The commit occurs the following cycle.
- app_wdf_wren without app_wdf_end: beat accepted identically. The end bit is not checked.
- Reset mid-operation:
  - In-flight reads are dropped with no valid pulse.
  - Queued writes are discarded uncommitted.
  - Calibration restarts.

Test Plan:
- Reset release -> init_calib_complete, app_rdy, app_wdf_rdy low for 16 cycles, high on cycle 16.
- Write cmd addr 0x0000010 with data 0x0123..CDEF, mask 0 -> read of 0x0000010 accepted at T returns the same 128-bit value with valid and end high exactly at T+4.
- Fill word 0x20 with 0xFF..FF, then masked write of 0x00..00 with mask 16'hFFFE -> readback 0xFF..FF00 (only byte 0 cleared).
- Write cmd issued 3 cycles before its data -> app_rdy low for those 3 cycles; a queued read is held off; after data it returns new data.
- Four data beats followed by four write cmds to 0x00,0x08,0x10,0x18, then four back-to-back reads -> valid on four consecutive cycles in order; app_wdf_rdy low after the 4th beat until the first commit.
- app_cmd=3'b011 accepted -> err_cmd=1, no valid pulse. Then assert rst during an outstanding read -> no app_rd_data_valid, err_cmd cleared.
